// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the PE context sequencer: state encoding,
// default widths and the loop-end clamp helper.
package pe_ctx_pkg;

    localparam int unsigned CTX_W_DEF  = 32'd121;
    localparam int unsigned DEPTH_DEF  = 32'd16;
    localparam int unsigned CP_W_DEF   = 32'd4;
    localparam int unsigned ITER_W_DEF = 32'd16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Effective last loop index: the requested loop end, but never past
    // the last loaded entry. Caller guarantees count >= 1.
    function automatic int unsigned end_index(input int unsigned loop_end,
                                              input int unsigned count);
        int unsigned last;
        last = count - 32'd1;
        if (loop_end < last) begin
            return loop_end;
        end else begin
            return last;
        end
    endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context storage: DEPTH x CTX_W register array, one synchronous write
// port and one registered read port. The read register is the
// sequencer's ctx_out, so it is reset and holds when no read is issued.
module pe_ctx_mem
    import pe_ctx_pkg::*;
#(
    parameter int unsigned CTX_W = CTX_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = CP_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [CTX_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [CTX_W-1:0] rd_data_o
);

    logic [CTX_W-1:0] mem_q [DEPTH];
    logic [CTX_W-1:0] rd_data_q;

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; holds the last word when no read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= {CTX_W{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pe_ctx_sequencer.sv
// PE context sequencer: serially loaded context cache replayed as a loop
// over [0, end_eff] for a programmable number of passes, with stall and
// abort. One registered context word per non-stalled cycle.
module pe_ctx_sequencer
    import pe_ctx_pkg::*;
#(
    parameter int unsigned CTX_W  = CTX_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CP_W   = CP_W_DEF,
    parameter int unsigned ITER_W = ITER_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ld_write,
    input  logic [CTX_W-1:0]  ld_data,
    input  logic              ld_clear,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [CP_W-1:0]   loop_end,
    input  logic [ITER_W-1:0] iter_cnt,
    output logic [CTX_W-1:0]  ctx_out,
    output logic              ctx_valid,
    output logic [CP_W-1:0]   CP,
    output logic              busy,
    output logic              done,
    output logic              ld_full
);

    // Write pointer needs to represent DEPTH itself (full).
    localparam int unsigned WP_W = CP_W + 32'd1;

    state_e              state_q;
    logic [WP_W-1:0]     wr_ptr_q;
    logic [ITER_W-1:0]   pass_q;
    logic [CP_W-1:0]     end_q;
    logic [ITER_W-1:0]   iter_q;
    logic [CP_W-1:0]     cp_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                full_q;

    logic [WP_W-1:0]     wr_ptr_d;
    logic [ITER_W:0]     pass_inc_s;
    logic [CP_W-1:0]     end_eff_s;
    logic                at_end_s;
    logic                final_s;
    logic                start_ok_s;
    logic                step_s;
    logic                wr_en_s;
    logic                rd_en_s;
    logic [CP_W-1:0]     rd_addr_s;

    assign wr_ptr_d   = wr_ptr_q + {{(WP_W-1){1'b0}}, 1'b1};
    assign pass_inc_s = {1'b0, pass_q} + {{ITER_W{1'b0}}, 1'b1};
    assign end_eff_s  = CP_W'(end_index(32'(loop_end), 32'(wr_ptr_q)));
    assign at_end_s   = (cp_q == end_q);
    assign final_s    = (iter_q != {ITER_W{1'b0}}) && (pass_inc_s == {1'b0, iter_q});

    // Cycle decode: accepted start, RUN advance, load write and the
    // next-CP read address that feeds the registered context word.
    always_comb begin
        start_ok_s = 1'b0;
        step_s     = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        rd_addr_s  = {CP_W{1'b0}};
        if (state_q == ST_IDLE) begin
            start_ok_s = start && (wr_ptr_q != {WP_W{1'b0}});
            wr_en_s    = ld_write && !ld_clear && !full_q;
        end else begin
            step_s = !abort && !stall;
        end
        if (start_ok_s) begin
            rd_en_s   = 1'b1;
            rd_addr_s = {CP_W{1'b0}};
        end else if (step_s && !at_end_s) begin
            rd_en_s   = 1'b1;
            rd_addr_s = cp_q + {{(CP_W-1){1'b0}}, 1'b1};
        end else if (step_s && !final_s) begin
            rd_en_s   = 1'b1;
            rd_addr_s = {CP_W{1'b0}};
        end else begin
            rd_en_s   = 1'b0;
            rd_addr_s = {CP_W{1'b0}};
        end
    end

    // Sequencer FSM with load pointer, pass counter and registered status.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {WP_W{1'b0}};
            pass_q   <= {ITER_W{1'b0}};
            end_q    <= {CP_W{1'b0}};
            iter_q   <= {ITER_W{1'b0}};
            cp_q     <= {CP_W{1'b0}};
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ld_clear) begin
                        wr_ptr_q <= {WP_W{1'b0}};
                        full_q   <= 1'b0;
                    end else if (wr_en_s) begin
                        wr_ptr_q <= wr_ptr_d;
                        full_q   <= (wr_ptr_d == WP_W'(DEPTH));
                    end
                    if (start_ok_s) begin
                        end_q   <= end_eff_s;
                        iter_q  <= iter_cnt;
                        pass_q  <= {ITER_W{1'b0}};
                        cp_q    <= {CP_W{1'b0}};
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Abort wins over stall and end-of-loop; no done.
                        cp_q    <= {CP_W{1'b0}};
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (stall) begin
                        state_q <= ST_RUN;
                    end else if (!at_end_s) begin
                        cp_q <= cp_q + {{(CP_W-1){1'b0}}, 1'b1};
                    end else if (final_s) begin
                        cp_q    <= {CP_W{1'b0}};
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        // Wrap with no bubble; infinite runs saturate the count.
                        cp_q <= {CP_W{1'b0}};
                        if (pass_q != {ITER_W{1'b1}}) begin
                            pass_q <= pass_inc_s[ITER_W-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    pe_ctx_mem #(
        .CTX_W (CTX_W),
        .DEPTH (DEPTH),
        .AW    (CP_W)
    ) u_mem (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q[CP_W-1:0]),
        .wr_data_i (ld_data),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (ctx_out)
    );

    assign ctx_valid = valid_q;
    assign CP        = cp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ld_full   = full_q;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed self-checking bench for pe_ctx_sequencer (default parameters).
module tb_pe_ctx_sequencer;

    localparam int CTX_W  = 121;
    localparam int CP_W   = 4;
    localparam int ITER_W = 16;

    logic              CLK;
    logic              RST_N;
    logic              ld_write;
    logic [CTX_W-1:0]  ld_data;
    logic              ld_clear;
    logic              start;
    logic              abort;
    logic              stall;
    logic [CP_W-1:0]   loop_end;
    logic [ITER_W-1:0] iter_cnt;
    logic [CTX_W-1:0]  ctx_out;
    logic              ctx_valid;
    logic [CP_W-1:0]   CP;
    logic              busy;
    logic              done;
    logic              ld_full;

    int tests;
    int fails;
    logic [CTX_W-1:0] w [4];
    logic [CTX_W-1:0] v [16];

    pe_ctx_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ld_write  (ld_write),
        .ld_data   (ld_data),
        .ld_clear  (ld_clear),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
        .loop_end  (loop_end),
        .iter_cnt  (iter_cnt),
        .ctx_out   (ctx_out),
        .ctx_valid (ctx_valid),
        .CP        (CP),
        .busy      (busy),
        .done      (done),
        .ld_full   (ld_full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ctx(input string tag, input logic [CTX_W-1:0] obs, input logic [CTX_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cp(input string tag, input logic [CP_W-1:0] obs, input logic [CP_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic ev, input logic eb, input logic ed);
        chk_b({tag, ".valid"}, ctx_valid, ev);
        chk_b({tag, ".busy"},  busy, eb);
        chk_b({tag, ".done"},  done, ed);
    endtask

    task automatic chk_word(input string tag, input logic [CTX_W-1:0] ew, input logic [CP_W-1:0] ecp);
        chk_ctx({tag, ".ctx"}, ctx_out, ew);
        chk_cp({tag, ".cp"}, CP, ecp);
        chk_st(tag, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk_ctx({tag, ".ctx"}, ctx_out, {CTX_W{1'b0}});
        chk_cp({tag, ".cp"}, CP, 4'd0);
        chk_st(tag, 1'b0, 1'b0, 1'b0);
        chk_b({tag, ".full"}, ld_full, 1'b0);
    endtask

    task automatic load(input logic [CTX_W-1:0] d);
        ld_write = 1'b1;
        ld_data  = d;
        tick();
        ld_write = 1'b0;
    endtask

    task automatic run_start(input logic [CP_W-1:0] le, input logic [ITER_W-1:0] it);
        loop_end = le;
        iter_cnt = it;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 4; i++) w[i] = 121'h1_2345_6789_ABCD_EF01_2345_6789_ABC0 + CTX_W'(i) * 121'h1_0000_0000_0000_0000_0000_0000_000A;
        for (int i = 0; i < 16; i++) v[i] = 121'h100 + CTX_W'(i);
        RST_N = 1'b0; ld_write = 1'b0; ld_data = '0; ld_clear = 1'b0;
        start = 1'b0; abort = 1'b0; stall = 1'b0; loop_end = '0; iter_cnt = '0;
        tick(); tick();
        chk_zero("reset");
        RST_N = 1'b1;
        tick();

        // Load four words
        for (int i = 0; i < 4; i++) load(w[i]);
        chk_b("load4.full", ld_full, 1'b0);

        // Basic loop, two passes
        run_start(4'd3, 16'd2);
        for (int k = 0; k < 8; k++) begin
            chk_word($sformatf("basic%0d", k), w[k % 4], CP_W'(k % 4));
            tick();
        end
        chk_st("basic.done", 1'b0, 1'b0, 1'b1);
        chk_cp("basic.done.cp", CP, 4'd0);
        chk_ctx("basic.hold", ctx_out, w[3]);
        // Start in the done cycle is accepted on the next edge
        run_start(4'd1, 16'd1);
        chk_word("bts0", w[0], 4'd0);
        tick();
        chk_word("bts1", w[1], 4'd1);
        tick();
        chk_st("bts.done", 1'b0, 1'b0, 1'b1);
        tick();
        chk_b("bts.done_one_cycle", done, 1'b0);

        // Stall three cycles on CP=1
        run_start(4'd3, 16'd2);
        chk_word("stall0", w[0], 4'd0);
        tick();
        chk_word("stall1", w[1], 4'd1);
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_word($sformatf("stallhold%0d", j), w[1], 4'd1);
        end
        stall = 1'b0;
        for (int k = 2; k < 8; k++) begin
            tick();
            chk_word($sformatf("stall%0d", k), w[k % 4], CP_W'(k % 4));
        end
        tick();
        chk_st("stall.done", 1'b0, 1'b0, 1'b1);

        // Clamp loop_end=10 to 3, infinite passes, then abort with stall
        tick();
        run_start(4'd10, 16'd0);
        for (int k = 0; k < 10; k++) begin
            chk_word($sformatf("inf%0d", k), w[k % 4], CP_W'(k % 4));
            tick();
        end
        chk_word("inf10", w[2], 4'd2);
        abort = 1'b1;
        stall = 1'b1;
        tick();
        abort = 1'b0;
        stall = 1'b0;
        chk_st("abort", 1'b0, 1'b0, 1'b0);
        chk_cp("abort.cp", CP, 4'd0);
        tick();
        chk_st("abort.after", 1'b0, 1'b0, 1'b0);

        // Load and start during RUN are ignored
        run_start(4'd3, 16'd1);
        chk_word("wr0", w[0], 4'd0);
        ld_write = 1'b1; ld_data = 121'hDEAD; start = 1'b1; loop_end = 4'd0; iter_cnt = 16'd5;
        tick();
        ld_write = 1'b0; start = 1'b0;
        chk_word("wr1", w[1], 4'd1);
        tick();
        chk_word("wr2", w[2], 4'd2);
        tick();
        chk_word("wr3", w[3], 4'd3);
        tick();
        chk_st("wr.done", 1'b0, 1'b0, 1'b1);
        run_start(4'd15, 16'd1);
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("wrchk%0d", k), w[k], CP_W'(k));
            tick();
        end
        chk_st("wrchk.done", 1'b0, 1'b0, 1'b1);
        chk_b("wrchk.full", ld_full, 1'b0);

        // Reset mid-run
        run_start(4'd3, 16'd0);
        tick(); tick();
        chk_word("rst.cp2", w[2], 4'd2);
        RST_N = 1'b0;
        #1;
        chk_zero("rst.async");
        tick();
        chk_st("rst.held", 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        run_start(4'd3, 16'd1);
        chk_st("rst.empty_start", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) load(w[i]);
        run_start(4'd3, 16'd1);
        chk_word("rst.replay0", w[0], 4'd0);
        tick();
        chk_word("rst.replay1", w[1], 4'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_st("rst.abort", 1'b0, 1'b0, 1'b0);

        // Load limits
        ld_clear = 1'b1;
        tick();
        ld_clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load(v[i]);
            chk_b($sformatf("fill%0d.full", i), ld_full, (i == 15));
        end
        load(121'hDEAD);
        chk_b("fill17.full", ld_full, 1'b1);
        run_start(4'd15, 16'd1);
        for (int k = 0; k < 16; k++) begin
            chk_word($sformatf("full%0d", k), v[k], CP_W'(k));
            tick();
        end
        chk_st("full.done", 1'b0, 1'b0, 1'b1);
        ld_clear = 1'b1; ld_write = 1'b1; ld_data = 121'hBEEF;
        tick();
        ld_clear = 1'b0; ld_write = 1'b0;
        chk_b("clr.full", ld_full, 1'b0);
        run_start(4'd0, 16'd1);
        chk_st("clr.start", 1'b0, 1'b0, 1'b0);
        tick();
        chk_st("clr.after", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
